// File: rtl/morse_led_timer.sv
// Morse LED timer: turns one accepted dot/dash symbol into a timed LED mark,
// then an intra-letter or inter-letter gap, before it accepts the next symbol.
module morse_led_timer #(
    parameter int TICK_DIV     = 25000000,
    parameter int DOT_UNITS    = 1,
    parameter int DASH_UNITS   = 3,
    parameter int GAP_UNITS    = 1,
    parameter int LETTER_UNITS = 3
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       sym_valid_i,
    input  logic       sym_i,
    input  logic       last_i,
    input  logic       clr_i,
    output logic       sym_ready_o,
    output logic       led_o,
    output logic       letter_done_o,
    output logic [1:0] state_o
);

    // Handshake: a symbol transfers on a rising edge where sym_valid_i and
    // sym_ready_o are both high (and clr_i is low); ready is high only in IDLE.

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MARK = 2'b01,
        GAP  = 2'b10,
        LGAP = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_cnt;
    logic [2:0]      unit_cnt;
    logic [2:0]      units_m1;
    logic            sym_q, last_q;
    logic            tick_end, phase_done, accept;
    logic            led_d, done_d;

    assign accept     = (state_q == IDLE) && sym_valid_i && !clr_i;
    assign tick_end   = (cyc_cnt == TICK_LAST);
    assign phase_done = tick_end && (unit_cnt == units_m1);

    always_comb begin
        units_m1 = 3'd0;
        case (state_q)
            MARK:    units_m1 = sym_q ? 3'(DASH_UNITS - 1) : 3'(DOT_UNITS - 1);
            GAP:     units_m1 = 3'(GAP_UNITS - 1);
            LGAP:    units_m1 = 3'(LETTER_UNITS - 1);
            default: units_m1 = 3'd0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (sym_valid_i) state_d = MARK;
                MARK:    if (phase_done) state_d = last_q ? LGAP : GAP;
                GAP:     if (phase_done) state_d = IDLE;
                LGAP:    if (phase_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A clear that lands on the final LGAP cycle must swallow the done pulse.
    always_comb begin
        led_d  = (state_d == MARK);
        done_d = (state_q == LGAP) && (state_d == IDLE) && !clr_i;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            led_o         <= 1'b0;
            letter_done_o <= 1'b0;
        end else begin
            led_o         <= led_d;
            letter_done_o <= done_d;
        end
    end

    // Counters restart on every state entry and sit at zero while idle.
    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            cyc_cnt  <= '0;
            unit_cnt <= 3'd0;
        end else if ((state_d != state_q) || (state_q == IDLE)) begin
            cyc_cnt  <= '0;
            unit_cnt <= 3'd0;
        end else if (tick_end) begin
            cyc_cnt  <= '0;
            unit_cnt <= unit_cnt + 3'd1;
        end else begin
            cyc_cnt  <= cyc_cnt + CW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            sym_q  <= 1'b0;
            last_q <= 1'b0;
        end else if (accept) begin
            sym_q  <= sym_i;
            last_q <= last_i;
        end
    end

    assign sym_ready_o = (state_q == IDLE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_morse_led_timer.sv
// Bench for morse_led_timer with a 4-cycle time unit: per-cycle expected
// {state, led, done, ready} vectors are queued as stimulus is driven.
module tb_morse_led_timer;

    localparam int TICK = 4;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_MARK = 2'b01;
    localparam logic [1:0] S_GAP  = 2'b10;
    localparam logic [1:0] S_LGAP = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sym_valid = 1'b0;
    logic       sym = 1'b0;
    logic       last = 1'b0;
    logic       clr = 1'b0;
    logic       sym_ready;
    logic       led;
    logic       letter_done;
    logic [1:0] state;

    logic [4:0] exp_q[$];
    string      cur_tag = "init";
    int         checks = 0;
    int         errors = 0;

    morse_led_timer #(
        .TICK_DIV    (TICK),
        .DOT_UNITS   (1),
        .DASH_UNITS  (3),
        .GAP_UNITS   (1),
        .LETTER_UNITS(3)
    ) dut (
        .CLOCK_50     (clk),
        .rst          (rst),
        .sym_valid_i  (sym_valid),
        .sym_i        (sym),
        .last_i       (last),
        .clr_i        (clr),
        .sym_ready_o  (sym_ready),
        .led_o        (led),
        .letter_done_o(letter_done),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    // Scoreboard: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        logic [4:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({cur_tag, ".state"}, {3'b000, state},       {3'b000, e[4:3]});
            check({cur_tag, ".led"},   {4'b0000, led},        {4'b0000, e[2]});
            check({cur_tag, ".done"},  {4'b0000, letter_done},{4'b0000, e[1]});
            check({cur_tag, ".ready"}, {4'b0000, sym_ready},  {4'b0000, e[0]});
        end
    end

    // Advance one edge, then queue the expected outputs for the new cycle.
    task automatic run(input int n, input logic [1:0] st, input logic l,
                       input logic d, input logic r);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back({st, l, d, r});
        end
    endtask

    // Drives one symbol that is accepted on the coming edge and queues its
    // whole mark/gap/idle trace; leaves the bench in the first idle cycle.
    task automatic send(input logic s, input logic l);
        int mark_c;
        int gap_c;
        mark_c = (s ? 3 : 1) * TICK;
        gap_c  = (l ? 3 : 1) * TICK;
        sym_valid = 1'b1;
        sym  = s;
        last = l;
        run(1, S_MARK, 1'b1, 1'b0, 1'b0);
        sym_valid = 1'b0;
        run(mark_c - 1, S_MARK, 1'b1, 1'b0, 1'b0);
        run(gap_c, l ? S_LGAP : S_GAP, 1'b0, 1'b0, 1'b0);
        run(1, S_IDLE, 1'b0, l, 1'b1);
    endtask

    initial begin
        // Reset held with valid high: no acceptance, idle outputs.
        cur_tag = "reset";
        sym_valid = 1'b1;
        run(3, S_IDLE, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;

        // Dot, last: accepted on first edge out of reset.
        cur_tag = "dot_last";
        sym = 1'b0;
        last = 1'b1;
        run(1, S_MARK, 1'b1, 1'b0, 1'b0);
        sym_valid = 1'b0;
        run(3, S_MARK, 1'b1, 1'b0, 1'b0);
        run(12, S_LGAP, 1'b0, 1'b0, 1'b0);
        run(1, S_IDLE, 1'b0, 1'b1, 1'b1);
        run(1, S_IDLE, 1'b0, 1'b0, 1'b1);

        cur_tag = "dash_gap";
        send(1'b1, 1'b0);
        run(1, S_IDLE, 1'b0, 1'b0, 1'b1);

        // Back-to-back with valid held high; second symbol waits for IDLE.
        cur_tag = "b2b";
        sym_valid = 1'b1;
        sym = 1'b0;
        last = 1'b0;
        run(1, S_MARK, 1'b1, 1'b0, 1'b0);
        sym = 1'b1;
        last = 1'b1;
        run(3, S_MARK, 1'b1, 1'b0, 1'b0);
        run(4, S_GAP, 1'b0, 1'b0, 1'b0);
        run(1, S_IDLE, 1'b0, 1'b0, 1'b1);
        run(1, S_MARK, 1'b1, 1'b0, 1'b0);
        sym_valid = 1'b0;
        run(11, S_MARK, 1'b1, 1'b0, 1'b0);
        run(12, S_LGAP, 1'b0, 1'b0, 1'b0);
        run(1, S_IDLE, 1'b0, 1'b1, 1'b1);
        run(1, S_IDLE, 1'b0, 1'b0, 1'b1);

        // Clear mid-dash with valid on the same edge.
        cur_tag = "clr_mark";
        sym_valid = 1'b1;
        sym = 1'b1;
        last = 1'b1;
        run(1, S_MARK, 1'b1, 1'b0, 1'b0);
        sym_valid = 1'b0;
        run(5, S_MARK, 1'b1, 1'b0, 1'b0);
        clr = 1'b1;
        sym_valid = 1'b1;
        run(1, S_IDLE, 1'b0, 1'b0, 1'b1);
        clr = 1'b0;
        cur_tag = "after_clr";
        send(1'b0, 1'b0);
        run(1, S_IDLE, 1'b0, 1'b0, 1'b1);

        // Clear on the final LGAP cycle suppresses letter_done.
        cur_tag = "clr_lgap";
        sym_valid = 1'b1;
        sym = 1'b0;
        last = 1'b1;
        run(1, S_MARK, 1'b1, 1'b0, 1'b0);
        sym_valid = 1'b0;
        run(3, S_MARK, 1'b1, 1'b0, 1'b0);
        run(12, S_LGAP, 1'b0, 1'b0, 1'b0);
        clr = 1'b1;
        run(1, S_IDLE, 1'b0, 1'b0, 1'b1);
        clr = 1'b0;
        run(1, S_IDLE, 1'b0, 1'b0, 1'b1);

        // Inputs toggling during MARK must not disturb the latched symbol.
        cur_tag = "ignore";
        sym_valid = 1'b1;
        sym = 1'b0;
        last = 1'b0;
        run(1, S_MARK, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sym = ~sym;
            last = ~last;
            sym_valid = i[0];
            run(1, S_MARK, 1'b1, 1'b0, 1'b0);
        end
        sym_valid = 1'b0;
        run(4, S_GAP, 1'b0, 1'b0, 1'b0);
        run(1, S_IDLE, 1'b0, 1'b0, 1'b1);

        cur_tag = "random";
        for (int i = 0; i < 4; i++) begin
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run($urandom_range(0, 2), S_IDLE, 1'b0, 1'b0, 1'b1);
        end

        @(posedge clk);
        @(posedge clk);
        cur_tag = "drain";
        check("queue_empty", 5'(exp_q.size()), 5'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
